// File: rtl/dw_mult_accum_dump.sv
// -----------------------------------------------------------------------------
// dw_mult_accum_dump
//
// Integrate-and-dump stage that sits behind the pipelined multiplier. The
// operand-valid / signedness pair is delayed to line up with PRODUCT. ACC_LEN
// aligned products are summed. The sum is then presented through a
// valid/ready output register.
//
// Optional feature macro: DW_MULT_ACCUM_SAT_EN
//   defined   -> the accumulate adder saturates. It uses signed limits when the
//                product's delayed TC is 1, and the unsigned maximum otherwise.
//   undefined -> the adder wraps modulo 2^ACC_width.
//
// Parameters:
//   P_width   width of PRODUCT
//   ACC_width accumulator / ACC_OUT width (>= P_width)
//   ACC_LEN   products per dump (1..65535)
//   LATENCY   multiplier latency = depth of the valid/TC delay line (>= 1)
//
// Ports:
//   CLK        rising-edge clock
//   rst_n      asynchronous active-low reset
//   IN_VALID   operands presented to the multiplier this cycle
//   TC         signedness of those operands
//   PRODUCT    multiplier output, LATENCY cycles behind IN_VALID/TC
//   CLEAR      synchronous flush (wins over everything except reset)
//   ACC_READY  consumer accepts ACC_OUT
//   ACC_VALID  ACC_OUT holds an unaccepted result
//   ACC_OUT    dumped sum
//   ACC_CNT    products accumulated in the current window
//   OVERRUN    sticky: a result was overwritten before it was accepted
// -----------------------------------------------------------------------------
module dw_mult_accum_dump #(
    parameter int P_width   = 32,
    parameter int ACC_width = 40,
    parameter int ACC_LEN   = 16,
    parameter int LATENCY   = 3
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 IN_VALID,
    input  logic                 TC,
    input  logic [P_width-1:0]   PRODUCT,
    input  logic                 CLEAR,
    input  logic                 ACC_READY,
    output logic                 ACC_VALID,
    output logic [ACC_width-1:0] ACC_OUT,
    output logic [15:0]          ACC_CNT,
    output logic                 OVERRUN
);

    // -------------------------------------------------------------------------
    // Valid/TC delay line. Each stage is its own register pair. The last stage
    // is the tap that lines up with PRODUCT.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_dly
            logic v_reg;
            logic tc_reg;
            logic v_in;
            logic tc_in;

            if (gi == 0) begin : g_first
                assign v_in  = IN_VALID;
                assign tc_in = TC;
            end else begin : g_rest
                assign v_in  = g_dly[gi-1].v_reg;
                assign tc_in = g_dly[gi-1].tc_reg;
            end

            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    v_reg  <= 1'b0;
                    tc_reg <= 1'b0;
                end else if (CLEAR) begin
                    // Flushing the line discards products already in flight.
                    v_reg  <= 1'b0;
                    tc_reg <= 1'b0;
                end else begin
                    v_reg  <= v_in;
                    tc_reg <= tc_in;
                end
            end
        end
    endgenerate

    logic v_d;
    logic tc_d;
    assign v_d  = g_dly[LATENCY-1].v_reg;
    assign tc_d = g_dly[LATENCY-1].tc_reg;

    // -------------------------------------------------------------------------
    // Accumulator state
    // -------------------------------------------------------------------------
    logic [ACC_width-1:0] acc_reg;
    logic [15:0]          cnt_reg;
    logic [ACC_width-1:0] acc_out_reg;
    logic                 acc_valid_reg;
    logic                 overrun_reg;

    logic [ACC_width-1:0] ext_prod;
    logic [ACC_width-1:0] acc_sum;
    logic                 last_in_window;

    // Each product is extended according to its own delayed TC. Mixed
    // signedness within a window is legal.
    always_comb begin
        ext_prod = tc_d ? ACC_width'($signed(PRODUCT)) : ACC_width'(PRODUCT);
    end

`ifdef DW_MULT_ACCUM_SAT_EN
    logic [ACC_width:0] sum_wide;

    always_comb begin
        sum_wide = {1'b0, acc_reg} + {1'b0, ext_prod};
        acc_sum  = sum_wide[ACC_width-1:0];
        if (tc_d) begin
            // Signed overflow occurs only when both addends share a sign and
            // the result flips it. Clamp toward the addends' sign.
            if ((acc_reg[ACC_width-1] == ext_prod[ACC_width-1]) &&
                (acc_sum[ACC_width-1] != acc_reg[ACC_width-1])) begin
                acc_sum = acc_reg[ACC_width-1] ? {1'b1, {(ACC_width-1){1'b0}}}
                                               : {1'b0, {(ACC_width-1){1'b1}}};
            end
        end else if (sum_wide[ACC_width]) begin
            acc_sum = '1;
        end
    end
`else
    assign acc_sum = acc_reg + ext_prod;
`endif

    assign last_in_window = (cnt_reg == 16'(ACC_LEN - 1));

    // The window state machine lives in cnt_reg. cnt_reg == 0 means the window
    // is empty. A valid product advances the count. The final product of the
    // window dumps the sum and returns the count to zero with no bubble.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            acc_out_reg   <= '0;
            acc_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (CLEAR) begin
            // ACC_OUT deliberately holds its last value.
            acc_reg       <= '0;
            cnt_reg       <= '0;
            acc_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            // A handshake consumes the held result. A dump in the same cycle
            // overrides this below.
            if (acc_valid_reg && ACC_READY) begin
                acc_valid_reg <= 1'b0;
            end

            if (v_d) begin
                if (last_in_window) begin
                    acc_out_reg   <= acc_sum;
                    acc_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                    cnt_reg       <= '0;
                    // Overwriting a result nobody took is sticky.
                    if (acc_valid_reg && !ACC_READY) begin
                        overrun_reg <= 1'b1;
                    end
                end else begin
                    acc_reg <= acc_sum;
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    end

    assign ACC_VALID = acc_valid_reg;
    assign ACC_OUT   = acc_out_reg;
    assign ACC_CNT   = cnt_reg;
    assign OVERRUN   = overrun_reg;

endmodule

// File: tb/tb_dw_mult_accum_dump.sv
// -----------------------------------------------------------------------------
// Testbench for dw_mult_accum_dump.
// Three instances share one stimulus stream:
//   inst 0: 32-bit product, 40-bit accumulator, ACC_LEN=4
//   inst 1: 32-bit product, 40-bit accumulator, ACC_LEN=1
//   inst 2:  8-bit product,  8-bit accumulator, ACC_LEN=2
// The reference model works at transaction level. An operand issued at edge k
// contributes at edge k+3 unless a flush happened at edges k..k+2. Its product
// is added with plain arithmetic and then wrapped or clamped.
// -----------------------------------------------------------------------------
module tb_dw_mult_accum_dump;

    localparam int LAT = 3;
    localparam int NC  = 4096;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        IN_VALID;
    logic        TC;
    logic [31:0] PRODUCT;
    logic        CLEAR;
    logic        ACC_READY;

    logic        va, vb, vc;
    logic [39:0] oa, ob;
    logic [7:0]  oc;
    logic [15:0] ca, cb, cc;
    logic        ra, rb, rc;

    always #5 CLK = ~CLK;

    dw_mult_accum_dump #(.P_width(32), .ACC_width(40), .ACC_LEN(4), .LATENCY(LAT)) dut_a (
        .CLK(CLK), .rst_n(rst_n), .IN_VALID(IN_VALID), .TC(TC), .PRODUCT(PRODUCT),
        .CLEAR(CLEAR), .ACC_READY(ACC_READY), .ACC_VALID(va), .ACC_OUT(oa),
        .ACC_CNT(ca), .OVERRUN(ra));

    dw_mult_accum_dump #(.P_width(32), .ACC_width(40), .ACC_LEN(1), .LATENCY(LAT)) dut_b (
        .CLK(CLK), .rst_n(rst_n), .IN_VALID(IN_VALID), .TC(TC), .PRODUCT(PRODUCT),
        .CLEAR(CLEAR), .ACC_READY(ACC_READY), .ACC_VALID(vb), .ACC_OUT(ob),
        .ACC_CNT(cb), .OVERRUN(rb));

    dw_mult_accum_dump #(.P_width(8), .ACC_width(8), .ACC_LEN(2), .LATENCY(LAT)) dut_c (
        .CLK(CLK), .rst_n(rst_n), .IN_VALID(IN_VALID), .TC(TC), .PRODUCT(PRODUCT[7:0]),
        .CLEAR(CLEAR), .ACC_READY(ACC_READY), .ACC_VALID(vc), .ACC_OUT(oc),
        .ACC_CNT(cc), .OVERRUN(rc));

    // Per-instance configuration
    int PW [3] = '{32, 32, 8};
    int AW [3] = '{40, 40, 8};
    int LEN[3] = '{4, 1, 2};

    // Model state
    longint unsigned m_acc[3];
    longint unsigned m_out[3];
    int              m_cnt[3];
    bit              m_vld[3];
    bit              m_ovr[3];

    // Stimulus history, indexed by edge number
    bit          iv_at   [NC];
    bit          tc_at   [NC];
    bit          sched_at[NC];
    logic [31:0] prod_at [NC];
    int          cyc   = 0;
    int          flush = -1;

    int checks   = 0;
    int failures = 0;

    function automatic longint unsigned mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint unsigned extend(input longint unsigned p, input bit tc,
                                               input int pw, input int aw);
        longint unsigned v;
        v = p & mask(pw);
        if (tc && (((v >> (pw - 1)) & 64'd1) == 64'd1)) v = v | ~mask(pw);
        return v & mask(aw);
    endfunction

    function automatic longint sx(input longint unsigned x, input int aw);
        if (((x >> (aw - 1)) & 64'd1) == 64'd1) return longint'(x | ~mask(aw));
        return longint'(x);
    endfunction

    function automatic longint unsigned add(input longint unsigned a, input longint unsigned e,
                                            input bit tc, input int aw);
`ifdef DW_MULT_ACCUM_SAT_EN
        longint unsigned su;
        longint s, hi, lo;
        if (!tc) begin
            su = a + e;
            if (su > mask(aw)) su = mask(aw);
            return su;
        end
        s  = sx(a, aw) + sx(e, aw);
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -hi - 1;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return longint'(s) & mask(aw);
`else
        if (tc) return (longint'(sx(a, aw) + sx(e, aw))) & mask(aw);
        return (a + e) & mask(aw);
`endif
    endfunction

    // Effect of the coming rising edge on instance i.
    task automatic model_step(input int i, input bit clr, input bit rdy, input logic [31:0] p);
        bit              tap;
        bit              tcd;
        bit              was_vld;
        longint unsigned s;
        if (clr) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_vld[i] = 0; m_ovr[i] = 0;
            return;
        end
        tap = (cyc >= LAT) && iv_at[cyc-LAT] && (flush < cyc - LAT);
        tcd = (cyc >= LAT) ? tc_at[cyc-LAT] : 1'b0;
        was_vld = m_vld[i];
        if (was_vld && rdy) m_vld[i] = 0;
        if (tap) begin
            s = add(m_acc[i], extend(64'(p), tcd, PW[i], AW[i]), tcd, AW[i]);
            if (m_cnt[i] == LEN[i] - 1) begin
                if (was_vld && !rdy) m_ovr[i] = 1;
                m_out[i] = s;
                m_vld[i] = 1;
                m_acc[i] = 0;
                m_cnt[i] = 0;
            end else begin
                m_acc[i] = s;
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=0x%0h expected=0x%0h", tag, inst, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("acc_valid", 0, 64'(va), 64'(m_vld[0]));
        chk("acc_out",   0, 64'(oa), m_out[0]);
        chk("acc_cnt",   0, 64'(ca), 64'(m_cnt[0]));
        chk("overrun",   0, 64'(ra), 64'(m_ovr[0]));
        chk("acc_valid", 1, 64'(vb), 64'(m_vld[1]));
        chk("acc_out",   1, 64'(ob), m_out[1]);
        chk("acc_cnt",   1, 64'(cb), 64'(m_cnt[1]));
        chk("overrun",   1, 64'(rb), 64'(m_ovr[1]));
        chk("acc_valid", 2, 64'(vc), 64'(m_vld[2]));
        chk("acc_out",   2, 64'(oc), m_out[2]);
        chk("acc_cnt",   2, 64'(cc), 64'(m_cnt[2]));
        chk("overrun",   2, 64'(rc), 64'(m_ovr[2]));
    endtask

    // One clock: drive inputs (we are just after a falling edge), advance the
    // model, then check after the next falling edge.
    task automatic tick(input bit iv, input bit tc, input logic [31:0] p, input bit clr);
        IN_VALID = iv;
        TC       = tc;
        CLEAR    = clr;
        iv_at[cyc] = iv;
        tc_at[cyc] = tc;
        if (iv) begin
            sched_at[cyc+LAT] = 1'b1;
            prod_at[cyc+LAT]  = p;
        end
        PRODUCT = sched_at[cyc] ? prod_at[cyc] : $urandom();
        for (int i = 0; i < 3; i++) model_step(i, clr, ACC_READY, PRODUCT);
        if (clr) flush = cyc;
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        $display("cyc=%0d iv=%0b tc=%0b clr=%0b rdy=%0b prod=%08h | a:v=%0b o=%0h c=%0d r=%0b b:v=%0b o=%0h r=%0b c:v=%0b o=%0h c=%0d r=%0b",
                 cyc, iv, tc, clr, ACC_READY, PRODUCT, va, oa, ca, ra, vb, ob, rb, vc, oc, cc, rc);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic op(input bit tc, input logic [31:0] p);
        tick(1'b1, tc, p, 1'b0);
    endtask

    task automatic clr_pulse();
        tick(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    // Async reset pulse between edges. Outputs must drop immediately.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_out[i] = 0; m_cnt[i] = 0; m_vld[i] = 0; m_ovr[i] = 0;
        end
        flush = cyc - 1;
        check_all();
        chk("rst_out_a", 0, 64'(oa), 64'd0);
        chk("rst_cnt_a", 0, 64'(ca), 64'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] sat_exp;
        rst_n     = 1'b0;
        IN_VALID  = 1'b0;
        TC        = 1'b0;
        PRODUCT   = 32'd0;
        CLEAR     = 1'b0;
        ACC_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_out[i] = 0; m_cnt[i] = 0; m_vld[i] = 0; m_ovr[i] = 0;
        end
        repeat (2) @(negedge CLK);
        check_all();
        rst_n = 1'b1;

        // Alignment: 1,2,3,4 unsigned -> 10
        clr_pulse();
        op(1'b0, 32'd1); op(1'b0, 32'd2); op(1'b0, 32'd3); op(1'b0, 32'd4);
        idle(4);
        chk("align_out",   0, 64'(oa), 64'd10);
        chk("align_valid", 0, 64'(va), 64'd1);
        chk("align_cnt",   0, 64'(ca), 64'd0);

        // Signed with gaps: -5,7,-,-,-1,-3 -> -2
        clr_pulse();
        op(1'b1, -32'sd5); op(1'b1, 32'd7); idle(2); op(1'b1, -32'sd1); op(1'b1, -32'sd3);
        idle(4);
        chk("signed_out", 0, 64'(oa), 64'hFF_FFFF_FFFE);

        // Backpressure on inst 2: 1,1,2,2 -> 2 then 4, overrun
        clr_pulse();
        op(1'b0, 32'd1); op(1'b0, 32'd1); op(1'b0, 32'd2); op(1'b0, 32'd2);
        idle(4);
        chk("bp_out",     2, 64'(oc), 64'd4);
        chk("bp_overrun", 2, 64'(rc), 64'd1);
        ACC_READY = 1'b1;
        idle(1);
        chk("bp_drop",    2, 64'(vc), 64'd0);
        chk("bp_sticky",  2, 64'(rc), 64'd1);
        clr_pulse();
        chk("bp_cleared", 2, 64'(rc), 64'd0);

        // Simultaneous dump/accept on inst 1: 3,5 with ready high
        op(1'b0, 32'd3); op(1'b0, 32'd5);
        idle(3);
        chk("sim_out",     1, 64'(ob), 64'd5);
        chk("sim_valid",   1, 64'(vb), 64'd1);
        chk("sim_overrun", 1, 64'(rb), 64'd0);

        // CLEAR mid-window discards in-flight products
        ACC_READY = 1'b0;
        clr_pulse();
        op(1'b0, 32'd9); op(1'b0, 32'd9); op(1'b0, 32'd9); op(1'b0, 32'd9);
        clr_pulse();
        chk("clr_cnt", 0, 64'(ca), 64'd0);
        op(1'b0, 32'd1); op(1'b0, 32'd1); op(1'b0, 32'd1); op(1'b0, 32'd1);
        idle(4);
        chk("clr_out", 0, 64'(oa), 64'd4);

        // Wrap / saturation on inst 2: signed 100+100
        clr_pulse();
        op(1'b1, 32'd100); op(1'b1, 32'd100);
        idle(4);
`ifdef DW_MULT_ACCUM_SAT_EN
        sat_exp = 8'h7F;
`else
        sat_exp = 8'hC8;
`endif
        chk("wrap_out", 2, 64'(oc), 64'(sat_exp));

        // Async reset mid-window
        op(1'b0, 32'd1); op(1'b0, 32'd1); op(1'b0, 32'd1);
        idle(1);
        pulse_reset();
        idle(4);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] p;
            ACC_READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) p = $urandom();
            else p = {{24{1'b0}}, 8'($urandom_range(0, 255))} ^ {32{$urandom_range(0, 1) == 1}};
            if (n == 200) begin
                pulse_reset();
            end
            tick(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, p,
                 ($urandom_range(0, 49) == 0));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
